// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, row synchronizer, debounced single-shot
// key strobe and a 4-nibble entry buffer (newest key in nibble 0).
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] show_value
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    state_t          state;
    logic [3:0]      sync1, rs;
    logic [DIVW-1:0] div;
    logic [CW-1:0]   cnt;
    logic [1:0]      col, row;

    logic            sample, any_low, row_low, accept, found;
    logic [1:0]      sel_row, col_nx;
    logic [3:0]      acc_code;

    always_comb begin
        sample   = (div == DIVW'(SCAN_DIV - 1));
        any_low  = (rs != 4'hF);
        row_low  = !rs[row];
        col_nx   = col + 2'd1;
        sel_row  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rs[i] && !found) begin
                sel_row = 2'(i);
                found   = 1'b1;
            end
        end
        // With a single required sample the press is accepted straight from SCAN.
        accept   = sample &&
                   ((state == SCAN && any_low && DEBOUNCE_SCANS == 1) ||
                    (state == DEBOUNCE && row_low && cnt == CW'(DEBOUNCE_SCANS - 1)));
        acc_code = (state == SCAN) ? {sel_row, col} : {row, col};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            sync1      <= 4'hF;
            rs         <= 4'hF;
            div        <= '0;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            col_n      <= 4'b1110;
            key_valid  <= 1'b0;
            key_code   <= '0;
            show_value <= '0;
        end else begin
            sync1     <= row_n;
            rs        <= sync1;
            key_valid <= accept;
            div       <= sample ? '0 : div + 1'b1;
            if (accept)
                key_code <= acc_code;
            if (clear)
                show_value <= '0;
            else if (accept)
                show_value <= {show_value[11:0], acc_code};

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            row <= sel_row;
                            if (accept) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= CW'(1);
                            end
                        end else begin
                            col   <= col_nx;
                            col_n <= ~(4'b0001 << col_nx);
                        end
                    end
                    DEBOUNCE: begin
                        if (row_low) begin
                            if (accept) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= SCAN;
                            cnt   <= '0;
                            col   <= col_nx;
                            col_n <= ~(4'b0001 << col_nx);
                        end
                    end
                    PRESSED: begin
                        if (!row_low) begin
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                state <= SCAN;
                                cnt   <= '0;
                                col   <= col_nx;
                                col_n <= ~(4'b0001 << col_nx);
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: a keypad matrix model drives the rows,
// expected {key_code, show_value} pairs are queued and checked on each key_valid.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n, col_n, row_n1, col_n1;
    logic        clear = 1'b0, clear1 = 1'b0;
    logic        key_valid, key_valid1;
    logic [3:0]  key_code, key_code1;
    logic [15:0] show_value, show_value1;
    logic [15:0] keys_down = '0, keys_down1 = '0;

    int errors = 0;
    int checks = 0;
    int pulses = 0, pulses1 = 0;
    logic [19:0] q[$];
    logic [19:0] q1[$];

    always #5 clk = ~clk;

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .clear(clear),
        .key_valid(key_valid), .key_code(key_code), .show_value(show_value));

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(1)) dut1 (
        .clk(clk), .reset(reset), .row_n(row_n1), .col_n(col_n1), .clear(clear1),
        .key_valid(key_valid1), .key_code(key_code1), .show_value(show_value1));

    // Keypad matrix: key k sits at row k/4, column k%4.
    always_comb begin
        row_n  = '1;
        row_n1 = '1;
        for (int k = 0; k < 16; k++) begin
            if (keys_down[k] && !col_n[k[1:0]])   row_n[k[3:2]]  = 1'b0;
            if (keys_down1[k] && !col_n1[k[1:0]]) row_n1[k[3:2]] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors
    logic prev_kv = 1'b0, prev_kv1 = 1'b0;
    always @(negedge clk) begin
        logic [19:0] e;
        if (key_valid) begin
            pulses++;
            chk("kv_not_back_to_back", 16'(prev_kv), 16'h0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 16'h1, 16'h0);
            end else begin
                e = q.pop_front();
                chk("key_code", 16'(key_code), 16'(e[19:16]));
                chk("show_value", show_value, e[15:0]);
            end
        end
        prev_kv = key_valid;
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (key_valid1) begin
            pulses1++;
            chk("ds1_kv_not_back_to_back", 16'(prev_kv1), 16'h0);
            if (q1.size() == 0) begin
                chk("ds1_unexpected_pulse", 16'h1, 16'h0);
            end else begin
                e = q1.pop_front();
                chk("ds1_key_code", 16'(key_code1), 16'(e[19:16]));
                chk("ds1_show_value", show_value1, e[15:0]);
            end
        end
        prev_kv1 = key_valid1;
    end

    task automatic wait_pulse(input int start, input string name);
        int n = 0;
        while (pulses == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pulses == start) chk({name, "_timeout"}, 16'h1, 16'h0);
    endtask

    // Wait for a fresh arrival of column pattern v on col_n.
    task automatic wait_fresh_col(input logic [3:0] v);
        int n = 0;
        while (col_n == v && n < 100) begin @(negedge clk); n++; end
        while (col_n != v && n < 100) begin @(negedge clk); n++; end
        if (col_n != v) chk("wait_col_timeout", 16'(col_n), 16'(v));
    endtask

    task automatic press(input int k, input logic [15:0] exp_show);
        int start = pulses;
        q.push_back({4'(k), exp_show});
        keys_down[k] = 1'b1;
        wait_pulse(start, "press");
        repeat (10) @(negedge clk);
        keys_down[k] = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        logic [3:0] prev;
        int dwell, trans, start, n;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_col_n", 16'(col_n), 16'h000E);
        chk("rst_key_valid", 16'(key_valid), 16'h0);
        chk("rst_key_code", 16'(key_code), 16'h0);
        chk("rst_show", show_value, 16'h0);
        reset = 1'b0;

        // Idle scan: rotation and 4-cycle dwell
        prev = col_n; dwell = 0; trans = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            dwell++;
            if (col_n != prev) begin
                chk("scan_rotate", 16'(col_n), 16'({prev[2:0], prev[3]}));
                if (trans > 0) chk("scan_dwell", 16'(dwell), 16'd4);
                trans++; dwell = 0; prev = col_n;
            end
        end
        chk("scan_transitions", 16'(trans >= 15), 16'h1);
        chk("idle_show", show_value, 16'h0);

        // Key 9: row 2, col 1
        start = pulses;
        q.push_back({4'h9, 16'h0009});
        keys_down[9] = 1'b1;
        wait_pulse(start, "key9");
        chk("key9_frozen", 16'(col_n), 16'h000D);
        repeat (20) @(negedge clk);
        chk("key9_still_frozen", 16'(col_n), 16'h000D);
        chk("key9_one_pulse", 16'(pulses - start), 16'h1);
        keys_down[9] = 1'b0;
        repeat (8) @(negedge clk);
        chk("key9_release_debounce", 16'(col_n), 16'h000D);
        n = 0;
        while (col_n == 4'hD && n < 40) begin @(negedge clk); n++; end
        chk("key9_resume", 16'(col_n), 16'h000B);

        // Keys 1..5 with buffer shift and overflow
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        chk("clear_show", show_value, 16'h0);
        start = pulses;
        press(1, 16'h0001);
        press(2, 16'h0012);
        press(3, 16'h0123);
        press(4, 16'h1234);
        chk("after4_show", show_value, 16'h1234);
        press(5, 16'h2345);
        chk("after5_show", show_value, 16'h2345);
        chk("five_pulses", 16'(pulses - start), 16'd5);

        // Bounce: one-sample glitch on key 7, then steady press held 200 cycles
        wait_fresh_col(4'h7);
        start = pulses;
        keys_down[7] = 1'b1;
        repeat (4) @(negedge clk);
        keys_down[7] = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_no_pulse", 16'(pulses - start), 16'h0);
        q.push_back({4'h7, 16'h3457});
        keys_down[7] = 1'b1;
        wait_pulse(start, "bounce");
        repeat (200) @(negedge clk);
        chk("held_one_pulse", 16'(pulses - start), 16'h1);
        keys_down[7] = 1'b0;
        repeat (40) @(negedge clk);

        // Rows 1 and 3 in column 2 with clear over the accept
        start = pulses;
        q.push_back({4'h6, 16'h0000});
        clear = 1'b1;
        keys_down[6] = 1'b1;
        keys_down[14] = 1'b1;
        wait_pulse(start, "multi");
        clear = 1'b0;
        @(negedge clk);
        chk("multi_code_hold", 16'(key_code), 16'h6);
        chk("multi_show_zero", show_value, 16'h0);
        keys_down[6] = 1'b0;
        keys_down[14] = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-PRESSED
        start = pulses;
        q.push_back({4'hD, 16'h000D});
        keys_down[13] = 1'b1;
        wait_pulse(start, "key13");
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstp_col_n", 16'(col_n), 16'h000E);
        chk("rstp_key_valid", 16'(key_valid), 16'h0);
        chk("rstp_show", show_value, 16'h0);
        chk("rstp_key_code", 16'(key_code), 16'h0);
        keys_down[13] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset mid-DEBOUNCE on key 2 (column 2)
        wait_fresh_col(4'hB);
        start = pulses;
        keys_down[2] = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstd_debouncing", 16'(col_n), 16'h000B);
        reset = 1'b1;
        @(negedge clk);
        chk("rstd_col_n", 16'(col_n), 16'h000E);
        chk("rstd_key_valid", 16'(key_valid), 16'h0);
        chk("rstd_show", show_value, 16'h0);
        keys_down[2] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstd_no_pulse", 16'(pulses - start), 16'h0);

        // DEBOUNCE_SCANS = 1: one low sample is accepted
        n = 0;
        while (col_n1 == 4'hD && n < 100) begin @(negedge clk); n++; end
        while (col_n1 != 4'hD && n < 100) begin @(negedge clk); n++; end
        start = pulses1;
        q1.push_back({4'h5, 16'h0005});
        keys_down1[5] = 1'b1;
        repeat (4) @(negedge clk);
        keys_down1[5] = 1'b0;
        n = 0;
        while (pulses1 == start && n < 10) begin @(negedge clk); n++; end
        chk("ds1_single_sample_pulse", 16'(pulses1 - start), 16'h1);
        repeat (30) @(negedge clk);

        chk("queue_empty", 16'(q.size()), 16'h0);
        chk("ds1_queue_empty", 16'(q1.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
